// File: rtl/tone_seq_gen.sv
// Chromatic square-wave tone generator: 12 notes x 8 octaves, optional
// ms duration, note changes at half-period boundaries, always ends low.
module tone_seq_gen #(
  parameter int unsigned CLK_HZ = 25_000_000,
  parameter int unsigned CNT_W  = 20,
  parameter int unsigned DUR_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [3:0]       note,
  input  logic [2:0]       octave,
  input  logic [DUR_W-1:0] dur,
  input  logic             stop,
  output logic             speaker,
  output logic             busy,
  output logic             note_done,
  output logic             err
);

  localparam int unsigned MS_DIV = CLK_HZ / 1000;
  localparam int unsigned PRE_W  =
    (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  function automatic logic [CNT_W-1:0] half_period(
    input longint unsigned f_mhz
  );
    return CNT_W'((64'(CLK_HZ) * 64'd1000) / (64'd2 * f_mhz));
  endfunction

  // Octave-0 half periods; slots 12..15 are never used
  localparam logic [CNT_W-1:0] BASE_HP [16] = '{
    half_period(16352), half_period(17324),
    half_period(18354), half_period(19445),
    half_period(20602), half_period(21827),
    half_period(23125), half_period(24500),
    half_period(25957), half_period(27500),
    half_period(29135), half_period(30868),
    half_period(30868), half_period(30868),
    half_period(30868), half_period(30868)
  };

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    STOPPING
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hp;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_hp;
  logic [DUR_W-1:0] pend_dur;
  logic [DUR_W-1:0] dur_rem;
  logic [PRE_W-1:0] pre;
  logic             pend_v;
  logic             timed;

  logic [CNT_W-1:0] shifted;
  logic [CNT_W-1:0] new_hp;
  logic [CNT_W-1:0] eff_hp;
  logic [DUR_W-1:0] eff_dur;
  logic             eff_v;
  logic             active;
  logic             toggle;
  logic             tick;
  logic             expire;
  logic             stop_req;
  logic             valid_note;
  logic             vload;

  always_comb begin
    shifted = BASE_HP[note] >> octave;
    new_hp  = (shifted < CNT_W'(2)) ? CNT_W'(2) : shifted;
  end

  assign active     = (state != IDLE);
  assign toggle     = active && (cnt == hp - 1'b1);
  assign tick       = active && (pre == PRE_W'(MS_DIV - 1));
  assign expire     = timed && tick && (dur_rem == DUR_W'(1));
  assign stop_req   = stop | expire;
  assign valid_note = (note <= 4'd11);
  assign vload      = load & valid_note & ~stop_req;

  // A load in this cycle is the newest pending note
  assign eff_v   = vload | pend_v;
  assign eff_hp  = vload ? new_hp : pend_hp;
  assign eff_dur = vload ? dur : pend_dur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hp        <= '0;
      cnt       <= '0;
      pend_hp   <= '0;
      pend_dur  <= '0;
      dur_rem   <= '0;
      pre       <= '0;
      pend_v    <= 1'b0;
      timed     <= 1'b0;
      speaker   <= 1'b0;
      busy      <= 1'b0;
      note_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      note_done <= 1'b0;
      err       <= load & ~valid_note & ~stop_req;
      if (active) begin
        cnt <= toggle ? '0 : cnt + 1'b1;
        pre <= tick ? '0 : pre + 1'b1;
        if (tick && timed) dur_rem <= dur_rem - 1'b1;
        if (expire) timed <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (vload) begin
            state   <= PLAY;
            hp      <= new_hp;
            dur_rem <= dur;
            timed   <= |dur;
            cnt     <= '0;
            pre     <= '0;
            speaker <= 1'b1;
            busy    <= 1'b1;
          end
        end
        PLAY: begin
          if (stop_req) begin
            pend_v <= 1'b0;
            if (speaker && !toggle) begin
              state <= STOPPING;
            end else begin
              state     <= IDLE;
              speaker   <= 1'b0;
              busy      <= 1'b0;
              note_done <= 1'b1;
            end
          end else begin
            pend_v   <= eff_v;
            pend_hp  <= eff_hp;
            pend_dur <= eff_dur;
            if (toggle) begin
              speaker <= ~speaker;
              if (eff_v) begin
                pend_v  <= 1'b0;
                hp      <= eff_hp;
                dur_rem <= eff_dur;
                timed   <= |eff_dur;
                pre     <= '0;
              end
            end
          end
        end
        STOPPING: begin
          pend_v   <= eff_v & ~stop_req;
          pend_hp  <= eff_hp;
          pend_dur <= eff_dur;
          if (toggle) begin
            speaker <= 1'b0;
            pend_v  <= 1'b0;
            if (eff_v && !stop_req) begin
              state   <= PLAY;
              hp      <= eff_hp;
              dur_rem <= eff_dur;
              timed   <= |eff_dur;
              pre     <= '0;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              note_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
